// File: rtl/mil_std_xmt_encoder.sv
// MIL-STD-1553 transmit encoder: one-word holding register feeding a Manchester II
// serialiser (3-bit-time sync, 16 data bits MSB first, odd parity) with gap-free chaining.
module mil_std_xmt_encoder #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BIT_RATE_HZ = 1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        enable_i,
  input  logic        send_i,
  input  logic [15:0] data_i,
  input  logic        sync_c_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovr_o,
  output logic        tx_p_o,
  output logic        tx_n_o,
  output logic        tx_en_o
);

  localparam int unsigned HALF_BIT_CYC = CLK_FREQ_HZ / (2 * BIT_RATE_HZ);
  localparam int unsigned CNT_W        = (HALF_BIT_CYC > 2) ? $clog2(HALF_BIT_CYC) : 1;
  localparam int unsigned IDX_W        = 6;
  localparam int unsigned DATA_W       = 16;
  localparam int unsigned SHIFT_W      = DATA_W + 1;
  localparam int unsigned SYNC_HALVES  = 6;
  localparam int unsigned DATA_HALVES  = 2 * SHIFT_W;

  if (((CLK_FREQ_HZ % (2 * BIT_RATE_HZ)) != 0) || (HALF_BIT_CYC < 2)) begin : g_bad_cfg
    $error("mil_std_xmt_encoder: CLK_FREQ_HZ/(2*BIT_RATE_HZ) must be exact and >= 2");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA} state_t;

  state_t               state, state_nxt;
  logic                 hold_valid;
  logic [DATA_W-1:0]    hold_data;
  logic                 hold_sync;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [SHIFT_W-1:0]   shift;
  logic                 frame_sync;

  logic accept, half_wrap, last_sync, last_data, load, active, level;
  logic tx_en_d, tx_p_d, tx_n_d, done_d, busy_d, ovr_d;

  assign ready_o   = enable_i & ~hold_valid;
  assign accept    = send_i & ready_o;
  assign active    = (state != ST_IDLE);
  assign half_wrap = active && (cnt == CNT_W'(HALF_BIT_CYC - 1));
  assign last_sync = (state == ST_SYNC) && half_wrap && (idx == IDX_W'(SYNC_HALVES - 1));
  assign last_data = (state == ST_DATA) && half_wrap && (idx == IDX_W'(DATA_HALVES - 1));
  assign load      = enable_i & hold_valid & ((state == ST_IDLE) | last_data);

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a held word chains straight into a new sync at frame end
  always_comb begin
    state_nxt = state;
    if (!enable_i) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (hold_valid) state_nxt = ST_SYNC;
        ST_SYNC: if (last_sync)  state_nxt = ST_DATA;
        ST_DATA: if (last_data)  state_nxt = hold_valid ? ST_SYNC : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Holding register, half-bit timing and shifter
  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_sync  <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      frame_sync <= 1'b0;
    end else begin
      if (accept) begin
        hold_valid <= 1'b1;
        hold_data  <= data_i;
        hold_sync  <= sync_c_i;
      end else if (load) begin
        hold_valid <= 1'b0;
      end
      if (load) begin
        shift      <= {hold_data, ~^hold_data};
        frame_sync <= hold_sync;
        cnt        <= '0;
        idx        <= '0;
      end else if (active) begin
        if (half_wrap) begin
          cnt <= '0;
          idx <= (last_sync || last_data) ? '0 : idx + IDX_W'(1);
          // Second half of a data bit done: move the next bit to the MSB
          if (state == ST_DATA && idx[0]) shift <= {shift[SHIFT_W-2:0], 1'b0};
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Output logic: next values of the registered outputs from the current state
  always_comb begin
    level = 1'b0;
    case (state)
      ST_SYNC: level = (idx < IDX_W'(SYNC_HALVES / 2)) ? frame_sync : ~frame_sync;
      ST_DATA: level = shift[SHIFT_W-1] ^ idx[0];
      default: level = 1'b0;
    endcase
    tx_en_d = enable_i & active;
    tx_p_d  = tx_en_d & level;
    tx_n_d  = tx_en_d & ~level;
    done_d  = enable_i & last_data;
    busy_d  = enable_i & (active | hold_valid);
    ovr_d   = send_i & enable_i & hold_valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_en_o <= 1'b0;
      tx_p_o  <= 1'b0;
      tx_n_o  <= 1'b0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
      ovr_o   <= 1'b0;
    end else begin
      tx_en_o <= tx_en_d;
      tx_p_o  <= tx_p_d;
      tx_n_o  <= tx_n_d;
      done_o  <= done_d;
      busy_o  <= busy_d;
      ovr_o   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_mil_std_xmt_encoder.sv
// Bench for mil_std_xmt_encoder: directed and random sends checked every cycle against
// a timeline model of accepted words (capture/transfer edges and frame waveforms).
module tb_mil_std_xmt_encoder;

  localparam int HBC   = 25;
  localparam int FRAME = 40 * HBC;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b1;
  logic        send_i = 1'b0;
  logic [15:0] data_i = '0;
  logic        sync_c_i = 1'b0;
  logic        ready_o, busy_o, done_o, ovr_o, tx_p_o, tx_n_o, tx_en_o;

  mil_std_xmt_encoder dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .send_i(send_i),
    .data_i(data_i), .sync_c_i(sync_c_i), .ready_o(ready_o), .busy_o(busy_o),
    .done_o(done_o), .ovr_o(ovr_o), .tx_p_o(tx_p_o), .tx_n_o(tx_n_o), .tx_en_o(tx_en_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got[6:0], exp[6:0]);
    end
  endtask

  // One accepted word: captured at edge c, moved to the line at edge t
  typedef struct {
    int          c;
    int          t;
    logic [15:0] d;
    logic        s;
  } word_t;

  word_t q[$];
  int    cyc = 0;
  logic  exp_busy = 1'b0;
  logic  exp_ovr  = 1'b0;

  function automatic logic held_at(input int m);
    foreach (q[i]) if (q[i].c <= m && m < q[i].t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic on_line_at(input int m);
    foreach (q[i]) if (q[i].t <= m && m <= q[i].t + FRAME - 1) return 1'b1;
    return 1'b0;
  endfunction

  // Line level k cycles into a frame: 6 sync half-bits, then 17 Manchester bits
  function automatic logic frame_level(input logic [15:0] d, input logic s, input int k);
    int half, j, b;
    logic v;
    half = k / HBC;
    if (half < 6) return (half < 3) ? s : ~s;
    j = half - 6;
    b = j / 2;
    v = (b < 16) ? d[15 - b] : ~^d;
    return (j % 2 == 0) ? v : ~v;
  endfunction

  // Model update at each edge from the inputs held during the previous cycle
  always @(posedge clk) begin
    logic hp, ap;
    int   line_end;
    word_t w;
    cyc++;
    hp = held_at(cyc - 1);
    ap = on_line_at(cyc - 1);
    exp_ovr = 1'b0;
    if (rst_i || !enable_i) begin
      q.delete();
      exp_busy = 1'b0;
    end else begin
      exp_busy = hp | ap;
      if (send_i) begin
        if (hp) begin
          exp_ovr = 1'b1;
        end else begin
          line_end = (q.size() > 0) ? q[q.size()-1].t + FRAME : 0;
          w.c = cyc;
          w.t = (cyc + 1 > line_end) ? cyc + 1 : line_end;
          w.d = data_i;
          w.s = sync_c_i;
          q.push_back(w);
        end
      end
    end
    while (q.size() > 0 && q[0].t + FRAME < cyc - 2) void'(q.pop_front());
  end

  // Compare every output each cycle, away from the active edge
  always @(negedge clk) begin
    logic act, lvl, dn;
    if (cyc >= 1) begin
      act = 1'b0; lvl = 1'b0; dn = 1'b0;
      foreach (q[i]) begin
        if (cyc >= q[i].t + 1 && cyc <= q[i].t + FRAME) begin
          act = 1'b1;
          lvl = frame_level(q[i].d, q[i].s, cyc - q[i].t - 1);
        end
        if (cyc == q[i].t + FRAME) dn = 1'b1;
      end
      check($sformatf("cyc%0d {en,p,n,done,busy,ready,ovr}", cyc),
            32'({tx_en_o, tx_p_o, tx_n_o, done_o, busy_o, ready_o, ovr_o}),
            32'({act, act & lvl, act & ~lvl, dn, exp_busy, enable_i & ~held_at(cyc), exp_ovr}));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [15:0] d, input logic s);
    send_i = 1'b1; data_i = d; sync_c_i = s;
    idle(1);
    send_i = 1'b0; data_i = $urandom(); sync_c_i = $urandom_range(0, 1);
  endtask

  initial begin
    idle(3);
    rst_i = 1'b0;
    idle(2);
    send(16'h0000, 1'b1);
    idle(FRAME + 10);
    send(16'h8001, 1'b0);
    idle(FRAME + 10);
    // Chained pair plus an overflowing third send
    send(16'h0001, 1'b1);
    idle(100);
    send(16'h0003, 1'b0);
    idle(100);
    send(16'h5555, 1'b1);
    idle(2 * FRAME + 10);
    // Abort by enable with a word held, then a clean frame
    send(16'h1234, 1'b1);
    idle(100);
    send(16'h4321, 1'b0);
    idle(148);
    enable_i = 1'b0;
    idle(3);
    enable_i = 1'b1;
    idle(5);
    send(16'hA5A5, 1'b1);
    idle(FRAME + 10);
    // Abort by reset mid-frame, then ready while disabled
    send(16'h0F0F, 1'b0);
    idle(40);
    send(16'h7777, 1'b1);
    idle(260);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    idle(5);
    enable_i = 1'b0;
    send(16'hFFFF, 1'b1);
    idle(4);
    enable_i = 1'b1;
    send(16'hC3C3, 1'b0);
    idle(FRAME + 10);
    // Random traffic
    for (int i = 0; i < 14; i++) begin
      int r;
      idle($urandom_range(0, 1300));
      r = $urandom_range(0, 9);
      if (r == 0) begin
        enable_i = 1'b0;
        idle($urandom_range(1, 3));
        enable_i = 1'b1;
      end else begin
        send(16'($urandom()), 1'($urandom_range(0, 1)));
        if (r < 5) begin
          idle($urandom_range(0, 1100));
          send(16'($urandom()), 1'($urandom_range(0, 1)));
        end
      end
    end
    idle(2 * FRAME + 10);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
